// File: rtl/uart_rx_param.sv
// uart_rx_param
// Oversampled UART receiver with run-time baud divisor, configurable data
// width, optional even/odd parity and one or two stop bits. Each bit is
// decided by a majority vote over three mid-bit samples. Received words are
// presented on a valid/ready output together with parity and framing flags.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rstb_i         synchronous reset, active high
//   rxd_i          asynchronous serial input, idle high
//   baud_div_i     tick period minus 1, in clk_i cycles (used live)
//   parity_mode_i  00 none, 01 even, 10 odd, 11 none (latched at start)
//   stop2_i        1 = two stop bits checked (latched at start)
//   data_o         received word, LSB = first data bit on the line
//   valid_o        data_o and the error flags are valid
//   ready_i        consumer accepts the presented word
//   parity_err_o   parity mismatch on the presented word
//   frame_err_o    a stop bit of the presented word was sampled low
//   overrun_o      sticky: a completed word was dropped
//   clr_ovr_i      clears overrun_o
//   fsm_state_o    current receiver state (debug)
//
// Output handshake: a word transfers in any cycle where valid_o && ready_i.
// valid_o, data_o and the flags hold steady until that cycle; valid_o drops
// in the next cycle unless a new word loads in the handshake cycle itself.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rstb_i,
  input  logic                 rxd_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 stop2_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 clr_ovr_i,
  output logic [2:0]           fsm_state_o
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           cfg_pmode;
  logic                 cfg_stop2;
  logic                 perr_acc, ferr_acc;

  logic tick, decide, wrap, maj, par_en, start_det, done, done_ferr, ovr_set;

  assign fsm_state_o = state;

  always_comb begin
    // >= rather than == so a divisor lowered mid-count still ticks at once
    tick       = (div_cnt >= baud_div_i);
    decide     = tick && (s_cnt == S_C);
    wrap       = tick && (s_cnt == S_LAST);
    // third sample is the live synchronised value at the decision tick
    maj        = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    par_en     = (cfg_pmode == 2'b01) || (cfg_pmode == 2'b10);
    done_ferr  = ferr_acc | ~maj;
    state_next = state;
    start_det  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (tick && !rx_s && rx_prev) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (decide && maj)  state_next = IDLE;  // false start
        else if (wrap)      state_next = DATA;
      end
      DATA: begin
        if (wrap && (bit_cnt == B_LAST)) state_next = par_en ? PARITY : STOP1;
      end
      PARITY: begin
        if (wrap) state_next = STOP1;
      end
      STOP1: begin
        // completion at the decision tick lets the next start edge be seen
        // in the second half of the stop bit
        if (decide && !cfg_stop2) begin
          state_next = IDLE;
          done       = 1'b1;
        end else if (wrap) begin
          state_next = STOP2;
        end
      end
      STOP2: begin
        if (decide) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    ovr_set = done && valid_o && !ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rstb_i) begin
      state        <= IDLE;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b1;
      div_cnt      <= '0;
      s_cnt        <= '0;
      bit_cnt      <= '0;
      samp_a       <= 1'b1;
      samp_b       <= 1'b1;
      shreg        <= '0;
      cfg_pmode    <= 2'b00;
      cfg_stop2    <= 1'b0;
      perr_acc     <= 1'b0;
      ferr_acc     <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      rx_meta <= rxd_i;
      rx_s    <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      state   <= state_next;

      if (tick) begin
        rx_prev <= rx_s;
        // s restarts at 0 on start detect and whenever the FSM is or
        // returns to IDLE; otherwise it counts 0..OVERSAMPLE-1 per bit
        if (state == IDLE || state_next == IDLE || s_cnt == S_LAST) s_cnt <= '0;
        else                                                        s_cnt <= s_cnt + SW'(1);
        if (s_cnt == S_A) samp_a <= rx_s;
        if (s_cnt == S_B) samp_b <= rx_s;
      end

      if (start_det) begin
        cfg_pmode <= parity_mode_i;
        cfg_stop2 <= stop2_i;
        perr_acc  <= 1'b0;
        ferr_acc  <= 1'b0;
        bit_cnt   <= '0;
      end

      if (wrap && state == DATA) bit_cnt <= bit_cnt + BW'(1);

      if (decide) begin
        case (state)
          DATA:    shreg    <= {maj, shreg[DATA_BITS-1:1]};
          PARITY:  perr_acc <= ((^shreg) ^ maj) != (cfg_pmode == 2'b10);
          STOP1:   ferr_acc <= ~maj;
          default: ;
        endcase
      end

      if (done && (!valid_o || ready_i)) begin
        data_o       <= shreg;
        parity_err_o <= perr_acc;
        frame_err_o  <= done_ferr;
        valid_o      <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      // a drop in the same cycle as a clear wins
      overrun_o <= (overrun_o & ~clr_ovr_i) | ovr_set;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
// Bench for uart_rx_param (DATA_BITS=8, OVERSAMPLE=16). Frames are driven
// bit by bit on rxd_i; a monitor pops expected {data, parity_err, frame_err}
// words from exp_q on every handshake. Expected words come from a table of
// hand-computed vectors and from a frame-level reference model.
module tb_uart_rx_param;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstb_i;
  logic          rxd_i;
  logic [DW-1:0] baud_div_i;
  logic [1:0]    parity_mode_i;
  logic          stop2_i;
  logic [DB-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          parity_err_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          clr_ovr_i;
  logic [2:0]    fsm_state_o;

  int n_vec   = 0;
  int n_err   = 0;
  int n_words = 0;

  logic [9:0] exp_q[$];
  logic [9:0] mon_w;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       stop2;
    logic       pbit;
    logic       s1;
    logic       s2;
    int         gbit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[13];

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
    .clk_i        (clk),
    .rstb_i       (rstb_i),
    .rxd_i        (rxd_i),
    .baud_div_i   (baud_div_i),
    .parity_mode_i(parity_mode_i),
    .stop2_i      (stop2_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .clr_ovr_i    (clr_ovr_i),
    .fsm_state_o  (fsm_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Frame-level reference: parity by counting ones, framing by stop levels.
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] pm,
                                       input logic st2, input logic pb,
                                       input logic s1, input logic s2);
    int   ones;
    logic perr;
    logic ferr;
    ones = $countones(d) + int'(pb);
    perr = 1'b0;
    if (pm == 2'b01)      perr = (ones % 2) != 0;
    else if (pm == 2'b10) perr = (ones % 2) == 0;
    ferr = !s1 || (st2 && !s2);
    return {d, perr, ferr};
  endfunction

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rstb_i && valid_o && ready_i) begin
      n_words++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got data=%h perr=%b ferr=%b, required none",
                 data_o, parity_err_o, frame_err_o);
      end else begin
        mon_w = exp_q.pop_front();
        check("word", {22'd0, data_o, parity_err_o, frame_err_o}, {22'd0, mon_w});
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge. Drives start, data, optional parity,
  // stop bit(s) and one idle bit. gbit inverts the line during cycles 36..39
  // of that bit, which reaches only the s=H sample at baud_div=3. The config
  // inputs are scrambled after the start bit to show they are latched.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic st2,
                            input logic pb, input logic s1, input logic s2,
                            input int gbit, input int abort_bit);
    logic q[$];
    int   p;
    p = (int'(baud_div_i) + 1) * OS;
    parity_mode_i = pm;
    stop2_i       = st2;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pm == 2'b01 || pm == 2'b10) q.push_back(pb);
    q.push_back(s1);
    if (st2) q.push_back(s2);
    q.push_back(1'b1);
    for (int b = 0; b < q.size(); b++) begin
      if (b == abort_bit) begin
        rxd_i = 1'b1;
        return;
      end
      for (int c = 0; c < p; c++) begin
        rxd_i = q[b] ^ ((b == gbit) && (c >= 36) && (c < 40));
        if (b == 1 && c == 0) begin
          parity_mode_i = 2'($urandom_range(0, 3));
          stop2_i       = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    logic found;
    logic [7:0] d;
    logic [1:0] pm;
    logic st2, pb, s1, s2;

    vecs[0]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 8'h55, 1'b0, 1'b0};
    vecs[1]  = '{8'hA3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 8'hA3, 1'b0, 1'b0};
    vecs[2]  = '{8'h07, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, -1, 8'h07, 1'b1, 1'b0};
    vecs[3]  = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, -1, 8'h07, 1'b0, 1'b0};
    vecs[4]  = '{8'h07, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, -1, 8'h07, 1'b0, 1'b0};
    vecs[5]  = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, -1, 8'h07, 1'b1, 1'b0};
    vecs[6]  = '{8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, -1, 8'h3C, 1'b0, 1'b1};
    vecs[7]  = '{8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{8'hB6, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1,  3, 8'hB6, 1'b0, 1'b0};
    vecs[9]  = '{8'hB6, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1,  1, 8'hB6, 1'b0, 1'b0};
    vecs[10] = '{8'h81, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, -1, 8'h81, 1'b0, 1'b0};
    vecs[11] = '{8'hF0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'hF0, 1'b0, 1'b1};
    vecs[12] = '{8'hC5, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, -1, 8'hC5, 1'b0, 1'b0};

    // reset
    rstb_i        = 1'b1;
    rxd_i         = 1'b1;
    baud_div_i    = 16'd3;
    parity_mode_i = 2'b00;
    stop2_i       = 1'b0;
    ready_i       = 1'b1;
    clr_ovr_i     = 1'b0;
    wait_cycles(3);
    check("reset_data",  32'(data_o), 32'h0);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_perr",  32'(parity_err_o), 32'h0);
    check("reset_ferr",  32'(frame_err_o), 32'h0);
    check("reset_ovr",   32'(overrun_o), 32'h0);
    check("reset_state", 32'(fsm_state_o), 32'h0);
    rstb_i = 1'b0;
    wait_cycles(70);

    // start edge to valid_o: 3..6 clk detection, 154 ticks of 4 clk, +1 clk
    exp_q.push_back({8'h5A, 1'b0, 1'b0});
    n = 0;
    found = 1'b0;
    fork
      send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      begin
        while (!found && n < 2000) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (valid_o) found = 1'b1;
        end
      end
    join
    n_vec++;
    if (!found || n < 618 || n > 623) begin
      n_err++;
      $display("FAIL valid_latency: got %0d cycles (seen=%b), required 618..623", n, found);
    end

    // table-driven frames at baud_div = 3
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      send_frame(vecs[i].data, vecs[i].pmode, vecs[i].stop2, vecs[i].pbit,
                 vecs[i].s1, vecs[i].s2, vecs[i].gbit, -1);
    end

    // glitch: 3 ticks low on an idle line is a false start
    base  = n_words;
    rxd_i = 1'b0;
    wait_cycles(12);
    check("glitch_in_start", 32'(fsm_state_o), 32'd1);
    rxd_i = 1'b1;
    wait_cycles(128);
    check("glitch_back_idle", 32'(fsm_state_o), 32'd0);
    check("glitch_no_word", 32'(n_words - base), 32'd0);

    // randomised frames against the reference model
    for (int i = 0; i < 20; i++) begin
      baud_div_i = 16'($urandom_range(1, 3));
      d   = 8'($urandom_range(0, 255));
      pm  = 2'($urandom_range(0, 3));
      st2 = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      s1  = ($urandom_range(0, 3) != 0);
      s2  = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(d, pm, st2, pb, s1, s2));
      send_frame(d, pm, st2, pb, s1, s2, -1, -1);
    end
    baud_div_i = 16'd3;
    wait_cycles(70);

    // overrun: second word dropped while the first is held
    ready_i = 1'b0;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
    check("ovr_data_held", 32'(data_o), 32'h11);
    check("ovr_valid_held", 32'(valid_o), 32'h1);
    check("ovr_flag_set", 32'(overrun_o), 32'h1);
    ready_i = 1'b1;
    wait_cycles(1);
    check("ovr_valid_drop", 32'(valid_o), 32'h0);
    check("ovr_flag_sticky", 32'(overrun_o), 32'h1);
    clr_ovr_i = 1'b1;
    wait_cycles(1);
    clr_ovr_i = 1'b0;
    check("ovr_flag_clear", 32'(overrun_o), 32'h0);

    // reset in the middle of DATA with a held word and overrun pending
    ready_i = 1'b0;
    send_frame(8'h66, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    send_frame(8'h67, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
    check("pre_rst_valid", 32'(valid_o), 32'h1);
    check("pre_rst_ovr", 32'(overrun_o), 32'h1);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4);
    check("pre_rst_in_data", 32'(fsm_state_o), 32'd2);
    base   = n_words;
    rstb_i = 1'b1;
    wait_cycles(1);
    rstb_i = 1'b0;
    check("mid_rst_data",  32'(data_o), 32'h0);
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    check("mid_rst_perr",  32'(parity_err_o), 32'h0);
    check("mid_rst_ferr",  32'(frame_err_o), 32'h0);
    check("mid_rst_ovr",   32'(overrun_o), 32'h0);
    check("mid_rst_state", 32'(fsm_state_o), 32'd0);
    ready_i = 1'b1;
    wait_cycles(12 * 64);
    check("mid_rst_no_word", 32'(n_words - base), 32'd0);
    exp_q.push_back({8'h9E, 1'b0, 1'b0});
    send_frame(8'h9E, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
    wait_cycles(20);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #900000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
